// File: rtl/cu_microsequencer.sv
// cu_microsequencer: registered next-state address sequencer for the microprogrammed control unit.
// Define MICRO_STACK_EN to build the call/return micro-stack; otherwise call acts as jump and return as fetch.
module cu_microsequencer #(
  parameter int            AW          = 8,
  parameter logic [AW-1:0] FETCH_ADDR  = AW'(1),
  parameter logic [AW-1:0] TRAP_ADDR   = AW'(8'hFF),
  parameter int            MOC_TIMEOUT = 16,
  parameter int            STACK_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [AW-1:0] IR_Addr,
  input  logic [AW-1:0] CR_Addr,
  input  logic [2:0]    N,
  input  logic          Inv,
  input  logic          Cond,
  input  logic          MOC,
  output logic [AW-1:0] State,
  output logic          Mem_Fault,
  output logic          Waiting,
  output logic          Stack_Err
);

  typedef enum logic [2:0] {
    OP_DISPATCH = 3'b000,
    OP_FETCH    = 3'b001,
    OP_JUMP     = 3'b010,
    OP_INCR     = 3'b011,
    OP_BRANCH   = 3'b100,
    OP_WAIT     = 3'b101,
    OP_CALL     = 3'b110,
    OP_RETURN   = 3'b111
  } op_e;

  // Wait counter is sized for the full 1..255 timeout range.
  localparam int             WCW     = 8;
  localparam logic [WCW-1:0] WC_LAST = WCW'(MOC_TIMEOUT - 1);

  op_e            op;
  logic [AW-1:0]  incr;
  logic           status;
  logic           moc_eff;
  logic [WCW-1:0] wc;
  logic [WCW-1:0] wc_next;
  logic [AW-1:0]  state_next;
  logic           fault_next;

  assign op      = op_e'(N);
  assign incr    = State + AW'(1);
  assign status  = Cond ^ Inv;
  assign moc_eff = MOC ^ Inv;
  assign Waiting = (op == OP_WAIT) && !moc_eff;

`ifdef MICRO_STACK_EN
  localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0]  stack_mem [STACK_DEPTH];
  logic [SPW:0]   sp;
  logic [SPW:0]   sp_next;
  logic           err_next;
  logic           push_en;
  logic [SPW-1:0] push_idx;
  logic [SPW-1:0] top_idx;
  logic           stack_full;
  logic           stack_empty;

  assign stack_full  = (sp == (SPW+1)'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign top_idx     = SPW'(sp - (SPW+1)'(1));
`endif

  always_comb begin
    state_next = State;
    wc_next    = '0;
    fault_next = 1'b0;
`ifdef MICRO_STACK_EN
    sp_next    = sp;
    err_next   = Stack_Err;
    push_en    = 1'b0;
    push_idx   = stack_full ? SPW'(STACK_DEPTH - 1) : sp[SPW-1:0];
`endif
    unique case (op)
      OP_DISPATCH: state_next = IR_Addr;
      OP_FETCH:    state_next = FETCH_ADDR;
      OP_JUMP:     state_next = CR_Addr;
      OP_INCR:     state_next = incr;
      OP_BRANCH:   state_next = status ? CR_Addr : incr;
      OP_WAIT: begin
        // A MOC arriving on the timeout cycle still completes the access.
        if (moc_eff) begin
          state_next = incr;
        end else if (wc == WC_LAST) begin
          state_next = TRAP_ADDR;
          fault_next = 1'b1;
        end else begin
          wc_next = wc + WCW'(1);
        end
      end
      OP_CALL: begin
        state_next = CR_Addr;
`ifdef MICRO_STACK_EN
        push_en = 1'b1;
        if (stack_full) begin
          err_next = 1'b1;
        end else begin
          sp_next = sp + (SPW+1)'(1);
        end
`endif
      end
      OP_RETURN: begin
`ifdef MICRO_STACK_EN
        if (stack_empty) begin
          state_next = FETCH_ADDR;
          err_next   = 1'b1;
        end else begin
          state_next = stack_mem[top_idx];
          sp_next    = sp - (SPW+1)'(1);
        end
`else
        state_next = FETCH_ADDR;
`endif
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      State     <= '0;
      wc        <= '0;
      Mem_Fault <= 1'b0;
    end else begin
      State     <= state_next;
      wc        <= wc_next;
      Mem_Fault <= fault_next;
    end
  end

`ifdef MICRO_STACK_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sp        <= '0;
      Stack_Err <= 1'b0;
    end else begin
      sp        <= sp_next;
      Stack_Err <= err_next;
    end
  end

  // Entries need no reset: the pointer alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push_en && !RESET) begin
      stack_mem[push_idx] <= incr;
    end
  end
`else
  logic stack_cfg_unused;

  assign Stack_Err        = 1'b0;
  assign stack_cfg_unused = (STACK_DEPTH > 0);
`endif

endmodule

// File: tb/tb_cu_microsequencer.sv
// Scoreboard bench for cu_microsequencer (AW=8, FETCH=1, TRAP=FF, timeout 16, depth 4).
// Stack expectations follow MICRO_STACK_EN as compiled.
module tb_cu_microsequencer;

  logic       CLK;
  logic       RESET;
  logic [7:0] IR_Addr;
  logic [7:0] CR_Addr;
  logic [2:0] N;
  logic       Inv;
  logic       Cond;
  logic       MOC;
  logic [7:0] State;
  logic       Mem_Fault;
  logic       Waiting;
  logic       Stack_Err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] st;
    logic       flt;
    logic       err;
    logic       wt;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [2:0] n;
    logic [7:0] ir;
    logic [7:0] cr;
    logic       cond;
    logic       inv;
    logic       moc;
    obs_t       exp;
  } row_t;

  obs_t sb[$];
  logic wait_s;

  cu_microsequencer #(
    .AW(8), .FETCH_ADDR(8'h01), .TRAP_ADDR(8'hFF), .MOC_TIMEOUT(16), .STACK_DEPTH(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .IR_Addr(IR_Addr), .CR_Addr(CR_Addr), .N(N),
    .Inv(Inv), .Cond(Cond), .MOC(MOC), .State(State), .Mem_Fault(Mem_Fault),
    .Waiting(Waiting), .Stack_Err(Stack_Err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  function automatic row_t r(input logic rst, input logic [2:0] n, input logic [7:0] ir,
                             input logic [7:0] cr, input logic cond, input logic inv,
                             input logic moc, input logic [7:0] st, input logic flt,
                             input logic err, input logic wt);
    row_t x;
    x.rst = rst; x.n = n; x.ir = ir; x.cr = cr;
    x.cond = cond; x.inv = inv; x.moc = moc;
    x.exp.st = st; x.exp.flt = flt; x.exp.err = err; x.exp.wt = wt;
    return x;
  endfunction

  // Drive one microinstruction, queue its expected result, sample Waiting before the edge.
  task automatic drive(input row_t x);
    RESET = x.rst; N = x.n; IR_Addr = x.ir; CR_Addr = x.cr;
    Cond = x.cond; Inv = x.inv; MOC = x.moc;
    sb.push_back(x.exp);
    #1 wait_s = Waiting;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    rows.push_back(r(1, 3'b010, 8'h00, 8'h33, 0, 0, 0, 8'h00, 0, 0, 0));
    rows.push_back(r(1, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
    for (int i = 0; i < rows.size(); i++) begin
      obs_t e, a;
      drive(rows[i]);
      e = sb.pop_front();
      a = {State, Mem_Fault, Stack_Err, wait_s};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL reset step %0d: got st=%h flt=%b err=%b wt=%b, want st=%h flt=%b err=%b wt=%b",
                 i, a.st, a.flt, a.err, a.wt, e.st, e.flt, e.err, e.wt);
      end
    end
  endtask

  task automatic test_dispatch();
    row_t rows[$];
    rows.push_back(r(0, 3'b001, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, 0, 0));
    rows.push_back(r(0, 3'b000, 8'h2A, 8'h00, 0, 0, 0, 8'h2A, 0, 0, 0));
    rows.push_back(r(0, 3'b000, 8'hC3, 8'h11, 0, 0, 0, 8'hC3, 0, 0, 0));
    rows.push_back(r(0, 3'b010, 8'h00, 8'h7E, 0, 0, 0, 8'h7E, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      obs_t e, a;
      drive(rows[i]);
      e = sb.pop_front();
      a = {State, Mem_Fault, Stack_Err, wait_s};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL dispatch step %0d: got st=%h flt=%b err=%b wt=%b, want st=%h flt=%b err=%b wt=%b",
                 i, a.st, a.flt, a.err, a.wt, e.st, e.flt, e.err, e.wt);
      end
    end
  endtask

  task automatic test_incr_branch();
    row_t rows[$];
    rows.push_back(r(0, 3'b010, 8'h00, 8'hFF, 0, 0, 0, 8'hFF, 0, 0, 0));
    rows.push_back(r(0, 3'b011, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    rows.push_back(r(0, 3'b011, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, 0, 0));
    rows.push_back(r(0, 3'b100, 8'h00, 8'h40, 1, 0, 0, 8'h40, 0, 0, 0));
    rows.push_back(r(0, 3'b100, 8'h00, 8'h80, 1, 1, 0, 8'h41, 0, 0, 0));
    rows.push_back(r(0, 3'b100, 8'h00, 8'h90, 0, 1, 0, 8'h90, 0, 0, 0));
    rows.push_back(r(0, 3'b100, 8'h00, 8'hA0, 0, 0, 0, 8'h91, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      obs_t e, a;
      drive(rows[i]);
      e = sb.pop_front();
      a = {State, Mem_Fault, Stack_Err, wait_s};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL incr_branch step %0d: got st=%h flt=%b err=%b wt=%b, want st=%h flt=%b err=%b wt=%b",
                 i, a.st, a.flt, a.err, a.wt, e.st, e.flt, e.err, e.wt);
      end
    end
  endtask

  task automatic test_moc_wait();
    row_t rows[$];
    rows.push_back(r(0, 3'b010, 8'h00, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0));
    for (int k = 0; k < 3; k++) rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'h10, 0, 0, 1));
    rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 1, 8'h11, 0, 0, 0));
    // Inverted MOC sense.
    rows.push_back(r(0, 3'b010, 8'h00, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0));
    rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 1, 1, 8'h10, 0, 0, 1));
    rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 1, 0, 8'h11, 0, 0, 0));
    // MOC lands on the same cycle the timeout would fire.
    rows.push_back(r(0, 3'b010, 8'h00, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0));
    for (int k = 0; k < 15; k++) rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'h10, 0, 0, 1));
    rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 1, 8'h11, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      obs_t e, a;
      drive(rows[i]);
      e = sb.pop_front();
      a = {State, Mem_Fault, Stack_Err, wait_s};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL moc_wait step %0d: got st=%h flt=%b err=%b wt=%b, want st=%h flt=%b err=%b wt=%b",
                 i, a.st, a.flt, a.err, a.wt, e.st, e.flt, e.err, e.wt);
      end
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    rows.push_back(r(0, 3'b010, 8'h00, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0));
    for (int k = 0; k < 15; k++) rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'h10, 0, 0, 1));
    rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 1, 0, 1));
    // Wait kept asserted after the trap: count restarts from zero.
    for (int k = 0; k < 15; k++) rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 0, 0, 1));
    rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 1, 0, 1));
    rows.push_back(r(0, 3'b011, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    // A fresh wait after a non-wait cycle needs the full count.
    rows.push_back(r(0, 3'b010, 8'h00, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0));
    for (int k = 0; k < 15; k++) rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'h10, 0, 0, 1));
    rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 1, 0, 1));
    for (int i = 0; i < rows.size(); i++) begin
      obs_t e, a;
      drive(rows[i]);
      e = sb.pop_front();
      a = {State, Mem_Fault, Stack_Err, wait_s};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL timeout step %0d: got st=%h flt=%b err=%b wt=%b, want st=%h flt=%b err=%b wt=%b",
                 i, a.st, a.flt, a.err, a.wt, e.st, e.flt, e.err, e.wt);
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    rows.push_back(r(0, 3'b010, 8'h00, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0));
    for (int k = 0; k < 7; k++) rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'h10, 0, 0, 1));
    rows.push_back(r(1, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
    for (int k = 0; k < 15; k++) rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1));
    rows.push_back(r(0, 3'b101, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 1, 0, 1));
    rows.push_back(r(0, 3'b011, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      obs_t e, a;
      drive(rows[i]);
      e = sb.pop_front();
      a = {State, Mem_Fault, Stack_Err, wait_s};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL reset_mid step %0d: got st=%h flt=%b err=%b wt=%b, want st=%h flt=%b err=%b wt=%b",
                 i, a.st, a.flt, a.err, a.wt, e.st, e.flt, e.err, e.wt);
      end
    end
  endtask

  task automatic test_stack();
    row_t rows[$];
`ifdef MICRO_STACK_EN
    rows.push_back(r(1, 3'b010, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    rows.push_back(r(0, 3'b010, 8'h00, 8'h20, 0, 0, 0, 8'h20, 0, 0, 0));
    rows.push_back(r(0, 3'b110, 8'h00, 8'h50, 0, 0, 0, 8'h50, 0, 0, 0));
    rows.push_back(r(0, 3'b111, 8'h00, 8'h00, 0, 0, 0, 8'h21, 0, 0, 0));
    // Stack ends as 22,61,62,63; the fifth push overwrites the top with 64.
    for (int k = 0; k < 5; k++)
      rows.push_back(r(0, 3'b110, 8'h00, 8'(8'h60 + k), 0, 0, 0, 8'(8'h60 + k), 0, (k == 4), 0));
    rows.push_back(r(0, 3'b111, 8'h00, 8'h00, 0, 0, 0, 8'h64, 0, 1, 0));
    rows.push_back(r(0, 3'b111, 8'h00, 8'h00, 0, 0, 0, 8'h62, 0, 1, 0));
    rows.push_back(r(0, 3'b111, 8'h00, 8'h00, 0, 0, 0, 8'h61, 0, 1, 0));
    rows.push_back(r(0, 3'b111, 8'h00, 8'h00, 0, 0, 0, 8'h22, 0, 1, 0));
    rows.push_back(r(0, 3'b111, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, 1, 0));
    rows.push_back(r(1, 3'b001, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    rows.push_back(r(0, 3'b111, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, 1, 0));
    rows.push_back(r(0, 3'b011, 8'h00, 8'h00, 0, 0, 0, 8'h02, 0, 1, 0));
`else
    rows.push_back(r(0, 3'b010, 8'h00, 8'h20, 0, 0, 0, 8'h20, 0, 0, 0));
    rows.push_back(r(0, 3'b110, 8'h00, 8'h77, 0, 0, 0, 8'h77, 0, 0, 0));
    rows.push_back(r(0, 3'b111, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, 0, 0));
    rows.push_back(r(0, 3'b110, 8'h00, 8'h05, 0, 0, 0, 8'h05, 0, 0, 0));
    rows.push_back(r(0, 3'b111, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, 0, 0));
`endif
    for (int i = 0; i < rows.size(); i++) begin
      obs_t e, a;
      drive(rows[i]);
      e = sb.pop_front();
      a = {State, Mem_Fault, Stack_Err, wait_s};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL stack step %0d: got st=%h flt=%b err=%b wt=%b, want st=%h flt=%b err=%b wt=%b",
                 i, a.st, a.flt, a.err, a.wt, e.st, e.flt, e.err, e.wt);
      end
    end
  endtask

  initial begin
    RESET = 1'b1; N = 3'b000; IR_Addr = '0; CR_Addr = '0;
    Inv = 1'b0; Cond = 1'b0; MOC = 1'b0;
    test_reset();
    test_dispatch();
    test_incr_branch();
    test_moc_wait();
    test_timeout();
    test_reset_mid();
    test_stack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
